volume_peak_tracker: RTL

- Sits directly upstream of the seven-segment sound display.
- Consumes a strobed 12-bit microphone sample stream and tracks the maximum sample over fixed windows of WINDOW samples.
- Publishes volume_raw, an instantaneous 0..15 level (volume_level_raw) and a peak-hold 0..15 level with timed decay (volume_level_peak).
- All outputs are registered and stable between window boundaries, so the display can sample them on any slow clock.

---
 rtl/sound_pkg.sv | 22 ++
 rtl/volume_level_quantizer.sv | 22 ++
 rtl/volume_peak_tracker.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared constants and types for the sound processing chain
// (microphone front end, level tracking and the seven-segment display).
package sound_pkg;

  localparam int SAMPLE_BITS = 12;
  localparam logic [SAMPLE_BITS-1:0] MIC_MID = 12'd2048;
  localparam int LEVEL_SHIFT = 7;
  localparam int LEVEL_W     = 4;

  typedef enum logic {
    TRACK = 1'b0,
    DECAY = 1'b1
  } hold_state_e;

  function automatic logic [SAMPLE_BITS-1:0] max_sample(
    input logic [SAMPLE_BITS-1:0] a,
    input logic [SAMPLE_BITS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/volume_level_quantizer.sv
// Maps an unsigned 12-bit microphone magnitude onto a 0..15 loudness level.
// Anything at or below mid-rail is silence; above it, each step is 128 codes.
module volume_level_quantizer
  import sound_pkg::*;
(
  input  logic [SAMPLE_BITS-1:0] m,
  output logic [LEVEL_W-1:0]     level
);

  logic [SAMPLE_BITS-1:0] excess;

  // The compare guards the subtraction so it can never wrap.
  always_comb begin
    excess = '0;
    level  = '0;
    if (m > MIC_MID) begin
      excess = m - MIC_MID;
      level  = LEVEL_W'(excess >> LEVEL_SHIFT);
    end
  end

endmodule

// File: rtl/volume_peak_tracker.sv
// Windowed maximum of a strobed microphone stream, with an instantaneous level
// and a peak-hold level that decays one step per window after a hold period.
module volume_peak_tracker
  import sound_pkg::*;
#(
  parameter int WINDOW   = 4000,
  parameter int HOLD_WIN = 5,
  parameter int SAMPLE_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-1:0] volume_raw,
  output logic [LEVEL_W-1:0]  volume_level_raw,
  output logic [LEVEL_W-1:0]  volume_level_peak,
  output logic                window_done
);

  localparam int CNT_W  = $clog2(WINDOW);
  localparam int HCNT_W = $clog2(HOLD_WIN) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WINDOW - 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(HOLD_WIN - 1);

  logic [CNT_W-1:0]    count_q, count_d;
  logic [SAMPLE_W-1:0] run_max_q, run_max_d;
  logic [SAMPLE_W-1:0] vol_raw_q, vol_raw_d;
  logic [LEVEL_W-1:0]  level_raw_q, level_raw_d;
  logic [LEVEL_W-1:0]  peak_q, peak_d;
  logic [HCNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                done_q, done_d;
  hold_state_e         state_q, state_d;

  logic                win_close;
  logic [SAMPLE_W-1:0] win_max;
  logic [LEVEL_W-1:0]  win_level;

  // The closing sample is folded into the maximum on the same edge.
  always_comb begin
    win_close = sample_valid && (count_q == LAST_CNT);
    win_max   = max_sample(run_max_q, sample);
  end

  volume_level_quantizer u_quant (
    .m     (win_max),
    .level (win_level)
  );

  always_comb begin
    count_d   = count_q;
    run_max_d = run_max_q;
    if (sample_valid) begin
      if (win_close) begin
        count_d   = '0;
        run_max_d = '0;
      end else begin
        count_d   = count_q + 1'b1;
        run_max_d = win_max;
      end
    end
  end

  always_comb begin
    vol_raw_d   = vol_raw_q;
    level_raw_d = level_raw_q;
    done_d      = win_close;
    if (win_close) begin
      vol_raw_d   = win_max;
      level_raw_d = win_level;
    end
  end

  always_comb begin
    state_d = state_q;
    if (win_close) begin
      if (win_level >= peak_q) begin
        state_d = TRACK;
      end else begin
        case (state_q)
          TRACK: if (hold_cnt_q >= HOLD_LAST) state_d = DECAY;
          DECAY: if ((peak_q - 1'b1) <= win_level) state_d = TRACK;
          default: state_d = TRACK;
        endcase
      end
    end
  end

  // In DECAY peak_q > win_level, so peak_q - 1 cannot underflow or undershoot.
  always_comb begin
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (win_close) begin
      if (win_level >= peak_q) begin
        peak_d     = win_level;
        hold_cnt_d = '0;
      end else begin
        case (state_q)
          TRACK: begin
            if (hold_cnt_q < HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
            else                        hold_cnt_d = '0;
          end
          DECAY: begin
            peak_d     = ((peak_q - 1'b1) < win_level) ? win_level : (peak_q - 1'b1);
            hold_cnt_d = '0;
          end
          default: hold_cnt_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      run_max_q   <= '0;
      vol_raw_q   <= '0;
      level_raw_q <= '0;
      peak_q      <= '0;
      hold_cnt_q  <= '0;
      done_q      <= 1'b0;
      state_q     <= TRACK;
    end else begin
      count_q     <= count_d;
      run_max_q   <= run_max_d;
      vol_raw_q   <= vol_raw_d;
      level_raw_q <= level_raw_d;
      peak_q      <= peak_d;
      hold_cnt_q  <= hold_cnt_d;
      done_q      <= done_d;
      state_q     <= state_d;
    end
  end

  assign volume_raw        = vol_raw_q;
  assign volume_level_raw  = level_raw_q;
  assign volume_level_peak = peak_q;
  assign window_done       = done_q;

endmodule
